// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, control-word layout and state encoding for the fetch stage
package fetch_pkg;
   localparam logic [15:0] NOP = 16'h0000;
   localparam int CTRL_VALID = 0;
   localparam int CTRL_FIRST = 1;
   localparam int CTRL_PC_LSB = 4;
   localparam int CTRL_PC_W = 12;
   typedef enum logic [1:0] {IDLE, FETCH, STALL, FLUSH} fetch_state_t;
   function automatic logic [15:0] make_ctrl(input logic [15:0] pc, input logic first);
      logic [15:0] c;
      c = '0;
      c[CTRL_VALID] = 1'b1;
      c[CTRL_FIRST] = first;
      c[CTRL_PC_LSB +: CTRL_PC_W] = pc[CTRL_PC_W-1:0];
      return c;
   endfunction
endpackage

// File: rtl/fetch_skid_reg.sv
// fetch_skid_reg: one-entry holding register for a word that returns while the stage is stalled
module fetch_skid_reg
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  logic        unload,
   input  logic [15:0] data_in,
   input  logic [15:0] tag_in,
   output logic [15:0] data,
   output logic [15:0] tag,
   output logic        valid
);
   // clear (redirect) beats load; unload empties the entry once presented
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         valid <= 1'b0;
         data  <= NOP;
         tag   <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= data_in;
         tag   <= tag_in;
      end else if (unload) begin
         valid <= 1'b0;
      end
endmodule

// File: rtl/ifid_fetch_unit.sv
// ifid_fetch_unit: IF stage feeding the IF/ID buffer; FETCH_PERF_CNT_EN adds a fetch_count output
module ifid_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'h0001
) (
   input  logic        Clk,
   input  logic        Reset,
   output logic        imem_rd,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] OutInstr,
   output logic [15:0] OutCtrl,
   output logic        out_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0] fetch_count
`endif
);
   fetch_state_t state, state_nxt;
   logic [15:0] pc, infl_pc, skid_data, skid_tag;
   logic infl, infl_first, first_pend, skid_valid;
   // reads are issued whenever not stalled or redirecting; the STALL state issues on its release cycle
   always_comb begin
      state_nxt = (redirect && !stall) ? FLUSH : stall ? STALL : FETCH;
      imem_rd = (state != IDLE) && !stall && !redirect;
   end
   assign imem_addr = pc;
   assign out_valid = OutCtrl[CTRL_VALID];
   // state register
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) state <= IDLE;
      else state <= state_nxt;
   // PC and in-flight read tracking; a redirect suppresses the read so the in-flight flag drops
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         pc         <= RESET_PC;
         infl       <= 1'b0;
         infl_pc    <= RESET_PC;
         infl_first <= 1'b0;
         first_pend <= 1'b0;
      end else begin
         infl <= imem_rd;
         if (imem_rd) begin
            infl_pc    <= pc;
            infl_first <= first_pend;
         end
         pc <= redirect ? redirect_pc : imem_rd ? pc + PC_STEP : pc;
         first_pend <= redirect || (first_pend && !imem_rd);
      end
   fetch_skid_reg u_skid (
      .clk     (Clk),
      .rst     (Reset),
      .load    (stall && infl && !redirect),
      .clear   (redirect),
      .unload  (!stall && skid_valid),
      .data_in (imem_data),
      .tag_in  (make_ctrl(infl_pc, infl_first)),
      .data    (skid_data),
      .tag     (skid_tag),
      .valid   (skid_valid)
   );
   // output register: frozen on stall, NOP on redirect, skid word takes precedence over the live return
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         OutInstr <= NOP;
         OutCtrl  <= '0;
      end else if (!stall) begin
         OutInstr <= redirect ? NOP : skid_valid ? skid_data : infl ? imem_data : NOP;
         OutCtrl  <= redirect ? '0 : skid_valid ? skid_tag : infl ? make_ctrl(infl_pc, infl_first) : '0;
      end
`ifdef FETCH_PERF_CNT_EN
   // counts cycles in which a valid instruction is handed on to IF/ID
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) fetch_count <= '0;
      else if (out_valid && !stall) fetch_count <= fetch_count + 16'd1;
`endif
endmodule

// File: tb/tb_ifid_fetch_unit.sv
// tb_ifid_fetch_unit: scoreboard bench for the fetch stage, including a wrap-around instance
module tb_ifid_fetch_unit;
   logic Clk = 1'b0, Reset = 1'b1, stall = 1'b0, redirect = 1'b0, st_q = 1'b0;
   logic [15:0] redirect_pc = '0, imem_data = '0, w_data = '0;
   logic imem_rd, out_valid, w_rd, w_valid;
   logic [15:0] imem_addr, OutInstr, OutCtrl, w_addr, w_instr, w_ctrl;
   logic [31:0] sb[$], wsb[$];
   logic [31:0] e_main, e_wrap;
   int n_err = 0, n_chk = 0;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_count, w_count;
`endif

   always #5 Clk = ~Clk;

   ifid_fetch_unit u_dut (
      .Clk(Clk), .Reset(Reset), .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .OutInstr(OutInstr), .OutCtrl(OutCtrl), .out_valid(out_valid)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_count(fetch_count)
`endif
   );

   ifid_fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
      .Clk(Clk), .Reset(Reset), .imem_rd(w_rd), .imem_addr(w_addr), .imem_data(w_data),
      .stall(1'b0), .redirect(1'b0), .redirect_pc(16'h0000),
      .OutInstr(w_instr), .OutCtrl(w_ctrl), .out_valid(w_valid)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_count(w_count)
`endif
   );

   // synchronous memories returning addr+0x1000; stall history for the monitor
   always @(posedge Clk) begin
      if (imem_rd) imem_data <= imem_addr + 16'h1000;
      if (w_rd) w_data <= w_addr + 16'h1000;
      st_q <= stall;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_w(input logic [15:0] pc, input logic first);
      logic [15:0] d;
      d = pc + 16'h1000;
      return {d, pc[11:0], 2'b00, first, 1'b1};
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // a new output is a valid word after an edge that did not sample stall
   always @(negedge Clk) begin
      if (!Reset && out_valid && !st_q) begin
         if (sb.size() == 0) chk("sb_extra", {OutInstr, OutCtrl}, 32'hxxxx_xxxx);
         else begin
            e_main = sb.pop_front();
            chk("sb_word", {OutInstr, OutCtrl}, e_main);
         end
      end
      if (!Reset && w_valid && wsb.size() > 0) begin
         e_wrap = wsb.pop_front();
         chk("wrap_word", {w_instr, w_ctrl}, e_wrap);
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) wsb.push_back(exp_w(16'hFFFE + 16'(i), 1'b0));
      repeat (2) step();
      chk("rst_rd", imem_rd, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_instr", OutInstr, 0);
      chk("rst_ctrl", OutCtrl, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_waddr", w_addr, 16'hFFFE);
      for (int i = 0; i < 6; i++) sb.push_back(exp_w(16'(i), 1'b0));
      Reset = 1'b0;
      step();
      chk("e1_rd", imem_rd, 1);
      chk("e1_addr", imem_addr, 0);
      chk("e1_valid", out_valid, 0);
      step();
      chk("e2_valid", out_valid, 0);
      step();
      chk("e3_valid", out_valid, 1);
      repeat (4) step();
      chk("pre_stall", OutInstr, 16'h1004);
      stall = 1'b1;
      #1;
      chk("stall_rd", imem_rd, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_hold", {OutInstr, OutCtrl}, exp_w(16'h0004, 1'b0));
      end
      stall = 1'b0;
      step();
      chk("pc7", imem_addr, 16'h0007);
      redirect = 1'b1;
      redirect_pc = 16'h0040;
      sb.push_back(exp_w(16'h0040, 1'b1));
      sb.push_back(exp_w(16'h0041, 1'b0));
      sb.push_back(exp_w(16'h0042, 1'b0));
      step();
      redirect = 1'b0;
      chk("bub1", {15'h0, out_valid, OutInstr}, 0);
      step();
      chk("bub2", {15'h0, out_valid, OutInstr}, 0);
      step();
      chk("tgt_ctrl", OutCtrl, 16'h0403);
      repeat (2) step();
      stall = 1'b1;
      redirect = 1'b1;
      sb.push_back(exp_w(16'h0040, 1'b1));
      sb.push_back(exp_w(16'h0041, 1'b0));
      step();
      redirect = 1'b0;
      chk("rs_hold1", {OutInstr, OutCtrl}, exp_w(16'h0042, 1'b0));
      step();
      chk("rs_hold2", {OutInstr, OutCtrl}, exp_w(16'h0042, 1'b0));
      stall = 1'b0;
      step();
      chk("rs_bubble", out_valid, 0);
      step();
      chk("rs_ctrl", OutCtrl, 16'h0403);
      step();
      @(negedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      chk("mid_rd", imem_rd, 0);
      chk("mid_addr", imem_addr, 0);
      chk("mid_instr", OutInstr, 0);
      chk("mid_ctrl", OutCtrl, 0);
      chk("mid_valid", out_valid, 0);
      chk("mid_wrd", w_rd, 0);
      chk("sb_drained", sb.size(), 0);
      repeat (2) step();
      for (int i = 0; i < 3; i++) sb.push_back(exp_w(16'(i), 1'b0));
      Reset = 1'b0;
      repeat (3) step();
      chk("re_e3_valid", out_valid, 1);
      repeat (2) step();
      @(negedge Clk);
      #1;
      chk("sb_end", sb.size(), 0);
      chk("wsb_end", wsb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
